// File: rtl/lru_age_update.sv
// True-LRU age updater for the 8192-set, 4-way replacement-state file.
// Reads one set, recomputes ages around the hit way, writes back changed fields one per cycle.
module lru_age_update (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [12:0] req_set,
   input  logic [3:0]  req_waysel,
   output logic [12:0] rf_ra,
   input  logic [11:0] rf_rdallways,
   output logic [12:0] rf_wa,
   output logic [3:0]  rf_wwaysel,
   output logic [2:0]  rf_wd,
   output logic        rf_wr,
   output logic        done,
   output logic [3:0]  victim_waysel
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [12:0] set_q, set_d;
   logic [1:0]  way_q, way_d;
   logic        nohit_q, nohit_d;
   logic [3:0]  pend_q, pend_d;
   logic [3:0]  victim_q, victim_d;
   logic [2:0]  age_q [4];
   logic [2:0]  age_d [4];

   logic [2:0]  rd_age  [4];
   logic [2:0]  new_age [4];
   logic [2:0]  hit_age;
   logic [3:0]  chg;
   logic [1:0]  wr_idx;
   logic [3:0]  wr_onehot;
   logic [3:0]  pend_rest;
   logic [2:0]  best_age;
   logic [1:0]  best_idx;

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else if (v[3]) return 2'd3;
      else           return 2'd0;
   endfunction

   assign hit_age = rd_age[way_q];

   // With no hit the ages pass through unchanged, so pend falls out as zero.
   for (genvar gi = 0; gi < 4; gi++) begin : g_way
      assign rd_age[gi] = rf_rdallways[3*gi +: 3];
      assign new_age[gi] = nohit_q                   ? rd_age[gi] :
                           (way_q == 2'(gi))         ? 3'd0 :
                           (rd_age[gi] < hit_age)    ? rd_age[gi] + 3'd1 :
                                                       rd_age[gi];
      assign chg[gi] = (new_age[gi] != rd_age[gi]);
   end

   always_comb begin
      best_age = new_age[0];
      best_idx = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (new_age[i] > best_age) begin
            best_age = new_age[i];
            best_idx = 2'(i);
         end
      end
   end

   assign wr_idx    = low_idx(pend_q);
   assign wr_onehot = 4'b0001 << wr_idx;
   assign pend_rest = pend_q & ~wr_onehot;

   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      way_d    = way_q;
      nohit_d  = nohit_q;
      pend_d   = pend_q;
      victim_d = victim_q;
      for (int i = 0; i < 4; i++) age_d[i] = age_q[i];

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               set_d   = req_set;
               way_d   = low_idx(req_waysel);
               nohit_d = (req_waysel == 4'b0000);
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            for (int i = 0; i < 4; i++) age_d[i] = new_age[i];
            pend_d   = chg;
            victim_d = 4'b0001 << best_idx;
            state_d  = (chg != 4'b0000) ? ST_WR : ST_DONE;
         end
         ST_WR: begin
            pend_d = pend_rest;
            if (pend_rest == 4'b0000) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         set_q    <= '0;
         way_q    <= '0;
         nohit_q  <= 1'b0;
         pend_q   <= '0;
         victim_q <= '0;
         for (int i = 0; i < 4; i++) age_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         set_q    <= set_d;
         way_q    <= way_d;
         nohit_q  <= nohit_d;
         pend_q   <= pend_d;
         victim_q <= victim_d;
         for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
      end
   end

   // Outputs decode straight from the state register so an async reset drops rf_wr at once.
   assign req_ready     = (state_q == ST_IDLE);
   assign rf_ra         = set_q;
   assign rf_wr         = (state_q == ST_WR);
   assign rf_wa         = rf_wr ? set_q : 13'd0;
   assign rf_wwaysel    = rf_wr ? wr_onehot : 4'b0000;
   assign rf_wd         = rf_wr ? age_q[wr_idx] : 3'd0;
   assign done          = (state_q == ST_DONE);
   assign victim_waysel = done ? victim_q : 4'b0000;

endmodule
